// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - pipeline-to-MDU request and HI/LO result bundle
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        we_hilo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // The EX stage issues requests and reads back HI/LO.
    modport master (
        output start, md_op, src_a, src_b, we_hilo,
        input  busy, hi, lo
    );

    // The multiply/divide unit answers requests and owns HI/LO.
    modport slave (
        input  start, md_op, src_a, src_b, we_hilo,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - fixed-latency multiply/divide unit with HI/LO registers
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_hilo_if.slave  bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [31:0]     pend_hi_q, pend_lo_q;
    logic            pend_wr_q;
    logic [31:0]     hi_q, lo_q;

    logic            start_accept;
    logic            commit;
    logic            mt_write;

    logic [63:0]     prod_s, prod_u;
    logic            a_neg, b_neg;
    logic [31:0]     abs_a, abs_b, div_s_den, div_u_den;
    logic [31:0]     uq_s, ur_s, q_u, r_u;
    logic [31:0]     res_hi, res_lo;
    logic            res_wr;

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Result of the requested operation, computed from the operands on the start cycle.
    always_comb begin
        prod_s    = {{32{bus.src_a[31]}}, bus.src_a} * {{32{bus.src_b[31]}}, bus.src_b};
        prod_u    = {32'd0, bus.src_a} * {32'd0, bus.src_b};
        a_neg     = bus.src_a[31];
        b_neg     = bus.src_b[31];
        abs_a     = a_neg ? (~bus.src_a + 32'd1) : bus.src_a;
        abs_b     = b_neg ? (~bus.src_b + 32'd1) : bus.src_b;
        // A zero divisor never commits, so substitute 1 to keep the dividers well defined.
        div_s_den = (abs_b == 32'd0) ? 32'd1 : abs_b;
        div_u_den = (bus.src_b == 32'd0) ? 32'd1 : bus.src_b;
        uq_s      = abs_a / div_s_den;
        ur_s      = abs_a % div_s_den;
        q_u       = bus.src_a / div_u_den;
        r_u       = bus.src_a % div_u_den;
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_wr    = 1'b1;
        case (bus.md_op[1:0])
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                // Magnitude divide then fix signs: quotient truncates toward zero,
                // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
                res_lo = (a_neg ^ b_neg) ? (~uq_s + 32'd1) : uq_s;
                res_hi = a_neg ? (~ur_s + 32'd1) : ur_s;
                res_wr = (bus.src_b != 32'd0);
            end
            default: begin
                res_lo = q_u;
                res_hi = r_u;
                res_wr = (bus.src_b != 32'd0);
            end
        endcase
    end

    // Request decode and next-state selection.
    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        commit       = 1'b0;
        mt_write     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.md_op[2]) begin
                    start_accept = 1'b1;
                    state_d      = RUN;
                end
                // A simultaneous start always wins over a HI/LO move.
                mt_write = bus.we_hilo && !bus.start &&
                           ((bus.md_op == OP_MTHI) || (bus.md_op == OP_MTLO));
            end
            RUN: begin
                if (count_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latency counter, pending result capture and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            if (start_accept) begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_wr_q <= res_wr;
                count_q   <= bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (state_q == RUN) begin
                count_q <= count_q - CW'(1);
            end

            if (commit && pend_wr_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end

            if (mt_write) begin
                if (bus.md_op == OP_MTHI) begin
                    hi_q <= bus.src_a;
                end else begin
                    lo_q <= bus.src_a;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - randomized self-checking bench for mdu_hilo
module tb_mdu_hilo;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mdu_hilo_if bus();

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural result of one mult/div request; wr=0 means HI/LO are left alone.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output bit wr, output logic [31:0] rh, output logic [31:0] rl);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        wr = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
            3'd2: begin
                if (b == 32'd0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin uq = ua / ub; ur = ua % ub; rl = uq[31:0]; rh = ur[31:0]; end
            end
        endcase
    endfunction

    // Issue one multi-cycle op, watch busy for its full latency, then check HI/LO.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input string name);
        int          n;
        bit          wr;
        logic [31:0] eh, el;
        n = (op < 3'd2) ? MC : DC;
        ref_op(op, a, b, wr, eh, el);
        bus.start   = 1'b1;
        bus.we_hilo = 1'b0;
        bus.md_op   = op;
        bus.src_a   = a;
        bus.src_b   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.md_op = 3'($urandom_range(0, 7));
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise: got %0b want 1", name, bus.busy);
        end
        for (int i = 1; i < n; i++) begin
            if (disturb && i == 2) begin
                bus.start   = 1'b1;
                bus.we_hilo = 1'b1;
                bus.md_op   = 3'($urandom_range(0, 5));
                bus.src_a   = $urandom;
                bus.src_b   = $urandom;
            end
            @(posedge clk); #1;
            bus.start   = 1'b0;
            bus.we_hilo = 1'b0;
            checks++;
            if (bus.busy !== 1'b1 || bus.hi !== model_hi || bus.lo !== model_lo) begin
                errors++;
                $display("FAIL %s during_busy cyc%0d: got busy=%0b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                         name, i, bus.busy, bus.hi, bus.lo, model_hi, model_lo);
            end
        end
        @(posedge clk); #1;
        if (wr) begin
            model_hi = eh;
            model_lo = el;
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== model_hi || bus.lo !== model_lo) begin
            errors++;
            $display("FAIL %s result op=%0d a=%h b=%h: got busy=%0b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     name, op, a, b, bus.busy, bus.hi, bus.lo, model_hi, model_lo);
        end
    endtask

    // Single-cycle mthi (sel=0) or mtlo (sel=1).
    task automatic write_hilo(input bit sel, input logic [31:0] val);
        bus.start   = 1'b0;
        bus.we_hilo = 1'b1;
        bus.md_op   = sel ? 3'd5 : 3'd4;
        bus.src_a   = val;
        bus.src_b   = $urandom;
        @(posedge clk); #1;
        bus.we_hilo = 1'b0;
        bus.md_op   = 3'd7;
        if (sel) model_lo = val;
        else     model_hi = val;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== model_hi || bus.lo !== model_lo) begin
            errors++;
            $display("FAIL mt_write sel=%0d: got busy=%0b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     sel, bus.busy, bus.hi, bus.lo, model_hi, model_lo);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.we_hilo = 1'b0;
        bus.md_op   = 3'd7;
        bus.src_a   = 32'd0;
        bus.src_b   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'd3, 32'hFFFFFFFE, 1'b0, "mult_3xm2");
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult_const: got hi=%h lo=%h want hi=ffffffff lo=fffffffa", bus.hi, bus.lo);
        end
        for (int k = 0; k < 8; k++) run_op(3'd0, $urandom, $urandom, 1'b0, "mult_rand");
    endtask

    task automatic test_multu();
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, "multu_max");
        checks++;
        if (bus.hi !== 32'h00000001 || bus.lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL multu_const: got hi=%h lo=%h want hi=00000001 lo=fffffffe", bus.hi, bus.lo);
        end
        for (int k = 0; k < 8; k++) run_op(3'd1, $urandom, $urandom, 1'b0, "multu_rand");
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, "div_m7_2");
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_const: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", bus.hi, bus.lo);
        end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_overflow_const: got hi=%h lo=%h want hi=00000000 lo=80000000", bus.hi, bus.lo);
        end
        for (int k = 0; k < 10; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 2) == 0) ? 32'($signed(8'($urandom))) : $urandom;
            run_op(3'd2, $urandom, d, 1'b0, "div_rand");
        end
    endtask

    task automatic test_divu();
        for (int k = 0; k < 10; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op(3'd3, $urandom, d, 1'b0, "divu_rand");
        end
    endtask

    task automatic test_div_zero();
        write_hilo(1'b0, 32'h12345678);
        write_hilo(1'b1, 32'h00000000);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, "divu_by_zero");
        checks++;
        if (bus.hi !== 32'h12345678 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL divu_zero_const: got hi=%h lo=%h want hi=12345678 lo=00000000", bus.hi, bus.lo);
        end
        run_op(3'd2, $urandom, 32'd0, 1'b0, "div_by_zero");
    endtask

    task automatic test_mthi_mtlo();
        for (int k = 0; k < 4; k++) write_hilo(k[0], $urandom);
    endtask

    task automatic test_ignored();
        logic [2:0] ops [4];
        ops = '{3'd6, 3'd7, 3'd4, 3'd5};
        foreach (ops[k]) begin
            bus.start   = 1'b1;
            bus.we_hilo = 1'b0;
            bus.md_op   = ops[k];
            bus.src_a   = $urandom;
            bus.src_b   = $urandom;
            @(posedge clk); #1;
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b0 || bus.hi !== model_hi || bus.lo !== model_lo) begin
                errors++;
                $display("FAIL ignored_start op=%0d: got busy=%0b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                         ops[k], bus.busy, bus.hi, bus.lo, model_hi, model_lo);
            end
        end
        bus.start   = 1'b1;
        bus.we_hilo = 1'b1;
        bus.md_op   = 3'd4;
        bus.src_a   = ~model_hi;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.we_hilo = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== model_hi) begin
            errors++;
            $display("FAIL start_beats_mthi: got busy=%0b hi=%h want busy=0 hi=%h", bus.busy, bus.hi, model_hi);
        end
        run_op(3'd0, $urandom, $urandom, 1'b1, "mult_disturbed");
        run_op(3'd3, $urandom, $urandom, 1'b1, "divu_disturbed");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++)
            run_op(3'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), "b2b");
    endtask

    task automatic test_reset_abort();
        bus.start   = 1'b1;
        bus.we_hilo = 1'b0;
        bus.md_op   = 3'd0;
        bus.src_a   = 32'd3;
        bus.src_b   = 32'd4;
        @(posedge clk); #1;
        bus.md_op = 3'd3;
        bus.src_a = 32'd8;
        bus.src_b = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %0b want 1", bus.busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset_edge: got busy=%0b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
                errors++;
                $display("FAIL abort_no_late_write cyc%0d: got busy=%0b hi=%h lo=%h want 0/0/0",
                         i, bus.busy, bus.hi, bus.lo);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_div_zero();
        test_mthi_mtlo();
        test_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
